// File: rtl/uart_program_loader_pkg.sv
// Shared types and defaults for the UART program loader.
// The FSM states use a 3-bit encoding: HUNT=0, ADDR=1, LEN=2, DATA=3, CSUM=4.
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } ldr_state_e;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'h55;

  // Running frame checksum: plain modulo-256 sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_program_loader_byte_strobe.sv
// Synchronises the receiver's done flag and emits one pulse per rising edge,
// so a done flag held high for many cycles yields a single accept.
module byte_strobe (
  input  logic clk,
  input  logic rst,
  input  logic rx_done_i,
  output logic accept_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_done_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign accept_o = sync2_q & ~prev_q;

endmodule

// File: rtl/uart_program_loader.sv
// Parses SYNC/ADDR/LEN/DATA/CSUM frames from the UART receiver, writes the data
// bytes into CPU RAM and holds the CPU halted until a frame checks out.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 4,
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_payload,
  input  logic                  rx_done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_data,
  output logic                  cpu_hold,
  output logic                  load_ok,
  output logic                  load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ldr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            rem_q, rem_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  hold_q, hold_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic                  accept;

  byte_strobe u_strobe (
    .clk       (clk),
    .rst       (rst),
    .rx_done_i (rx_done),
    .accept_o  (accept)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      ptr_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    hold_d  = hold_q;
    ok_d    = ok_q;
    err_d   = err_q;

    if (accept) begin
      tmo_d = '0;
      unique case (state_q)
        ST_HUNT: begin
          if (rx_payload == SYNC_BYTE) begin
            state_d = ST_ADDR;
            hold_d  = 1'b1;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            csum_d  = '0;
          end
        end
        ST_ADDR: begin
          ptr_d   = rx_payload[ADDR_WIDTH-1:0];
          csum_d  = csum_add(csum_q, rx_payload);
          state_d = ST_LEN;
        end
        ST_LEN: begin
          rem_d   = rx_payload;
          csum_d  = csum_add(csum_q, rx_payload);
          state_d = (rx_payload == 8'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          we_d    = 1'b1;
          addr_d  = ptr_q;
          data_d  = rx_payload;
          ptr_d   = ptr_q + 1'b1;
          rem_d   = rem_q - 8'd1;
          csum_d  = csum_add(csum_q, rx_payload);
          if (rem_q == 8'd1) state_d = ST_CSUM;
        end
        ST_CSUM: begin
          if (rx_payload == csum_q) begin
            ok_d   = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d  = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT) begin
      // Inter-byte gap too long: abandon the frame but keep the CPU halted.
      if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = ST_HUNT;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign cpu_hold = hold_q;
  assign load_ok  = ok_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed frames into the loader; a forked monitor checks RAM writes against a
// scoreboard queue while the main thread checks the status flags.
module tb_uart_program_loader;

  localparam int AW  = 4;
  localparam int TMO = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_payload = '0;
  logic          rx_done = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          cpu_hold, load_ok, load_err;

  int checks = 0;
  int failures = 0;
  logic [AW+7:0] exp_q[$];

  uart_program_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_payload(rx_payload), .rx_done(rx_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .load_ok(load_ok), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b, input int hold_cyc = 5);
    @(negedge clk);
    rx_payload = b;
    rx_done    = 1'b1;
    repeat (hold_cyc) @(negedge clk);
    rx_done = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_flags(input string nm, input logic ok, input logic err, input logic hold);
    checks++;
    if (load_ok !== ok || load_err !== err || cpu_hold !== hold) begin
      failures++;
      $display("FAIL %s: ok/err/hold got %b%b%b want %b%b%b", nm, load_ok, load_err, cpu_hold, ok, err, hold);
    end
  endtask

  task automatic check_queue(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d expected writes missing", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mem_we === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got addr=%h data=%h want none", mem_addr, mem_data);
          end else begin
            logic [AW+7:0] e;
            e = exp_q.pop_front();
            if ({mem_addr, mem_data} !== e) begin
              failures++;
              $display("FAIL write: got addr=%h data=%h want addr=%h data=%h",
                       mem_addr, mem_data, e[AW+7:8], e[7:0]);
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_mem: got we=%b addr=%h data=%h want 0 0 00", mem_we, mem_addr, mem_data);
    end
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: good frame 55 00 03 01 02 03 09
    expect_wr(4'h0, 8'h01); expect_wr(4'h1, 8'h02); expect_wr(4'h2, 8'h03);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    check_flags("f1_midframe", 1'b0, 1'b0, 1'b1);
    send_byte(8'h09);
    check_queue("f1_writes");
    check_flags("f1_good", 1'b1, 1'b0, 1'b0);

    // 2: same frame, bad checksum 0A
    expect_wr(4'h0, 8'h01); expect_wr(4'h1, 8'h02); expect_wr(4'h2, 8'h03);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h0A);
    check_queue("f2_writes");
    check_flags("f2_bad", 1'b0, 1'b1, 1'b1);

    // 3: address wrap; 0E+03+AA+BB+CC = 0x242 -> 42
    expect_wr(4'hE, 8'hAA); expect_wr(4'hF, 8'hBB); expect_wr(4'h0, 8'hCC);
    send_byte(8'h55); send_byte(8'h0E); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h42);
    check_queue("f3_wrap");
    check_flags("f3_good", 1'b1, 1'b0, 1'b0);

    // 4: data byte held 100 cycles must accept once; 00+02+11+22 = 35
    expect_wr(4'h0, 8'h11); expect_wr(4'h1, 8'h22);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11, 100); send_byte(8'h22); send_byte(8'h35);
    check_queue("f4_long_done");
    check_flags("f4_good", 1'b1, 1'b0, 1'b0);
    send_byte(8'h12); send_byte(8'h34);
    check_flags("f4_idle", 1'b1, 1'b0, 1'b0);

    // 5: timeout after two of five data bytes, then recovery
    expect_wr(4'h0, 8'h01); expect_wr(4'h1, 8'h02);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h02);
    check_flags("f5_pre_timeout", 1'b0, 1'b0, 1'b1);
    repeat (TMO + 20) @(negedge clk);
    check_queue("f5_writes");
    check_flags("f5_timeout", 1'b0, 1'b1, 1'b1);
    expect_wr(4'h3, 8'h07);
    send_byte(8'h55); send_byte(8'h03); send_byte(8'h01);
    send_byte(8'h07); send_byte(8'h0B);
    check_queue("f5_recover_wr");
    check_flags("f5_recover", 1'b1, 1'b0, 1'b0);

    // 6: reset during DATA, then 55 00 00 02 fails checksum
    expect_wr(4'h5, 8'h66);
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h04); send_byte(8'h66);
    check_queue("f6_pre_rst");
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_mem: got we=%b addr=%h data=%h want 0 0 00", mem_we, mem_addr, mem_data);
    end
    check_flags("rst_mid_flags", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    check_flags("f6_bad", 1'b0, 1'b1, 1'b1);
    check_queue("final_writes");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
